// File: rtl/display_scheduler.sv
// Four-digit seven-segment scanner that time-shares the display between roller text (A)
// and the calculator sum (B), switching source only at frame boundaries; also blinks overflow.
module display_scheduler #(
   parameter int HOLD_FRAMES  = 250,
   parameter int BLANK_CYCLES = 4,
   parameter int BLINK_FRAMES = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scan_tick,
   input  logic [27:0] src_a,
   input  logic [27:0] src_b,
   input  logic        b_req,
   input  logic        M,
   input  logic        overflow,
   output logic [6:0]  C,
   output logic        AN3,
   output logic        AN2,
   output logic        AN1,
   output logic        AN0,
   output logic        showing_b,
   output logic        overflow_led
);

   localparam logic [9:0] HOLD_RELOAD  = 10'(HOLD_FRAMES - 1);
   localparam logic [3:0] BLANK_LOAD   = 4'(BLANK_CYCLES);
   localparam logic [7:0] BLINK_RELOAD = 8'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {SRC_A, SRC_B_HOLD, SRC_B_FORCE} src_state_t;

   src_state_t state_reg, state_next;
   logic [9:0] hold_reg, hold_next;
   logic       pending_reg, pending_next;
   logic       showing_b_reg;
   logic [1:0] idx_reg;
   logic [3:0] blank_reg;
   logic       wait_reg;
   logic [3:0] an_reg;
   logic [6:0] c_reg;
   logic [7:0] blink_reg;
   logic       led_reg;

   logic [6:0] code_a [4];
   logic [6:0] code_b [4];
   logic [6:0] cur_code;
   logic       frame_tick;
   logic       req;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_unpack
         assign code_a[gi] = src_a[gi*7 +: 7];
         assign code_b[gi] = src_b[gi*7 +: 7];
      end
   endgenerate

   // A frame starts on the tick that wraps the digit index from 0 back to 3.
   assign frame_tick = scan_tick && (idx_reg == 2'd0);
   assign req        = pending_reg | b_req;
   assign cur_code   = (state_reg != SRC_A) ? code_b[idx_reg] : code_a[idx_reg];

   always_comb begin
      state_next   = state_reg;
      hold_next    = hold_reg;
      pending_next = req;
      if (frame_tick) begin
         case (state_reg)
            SRC_A: begin
               if (M) begin
                  state_next = SRC_B_FORCE;
               end else if (req) begin
                  state_next   = SRC_B_HOLD;
                  hold_next    = HOLD_RELOAD;
                  pending_next = 1'b0;
               end
            end
            SRC_B_HOLD: begin
               if (M) begin
                  state_next = SRC_B_FORCE;
               end else if (req) begin
                  hold_next    = HOLD_RELOAD;
                  pending_next = 1'b0;
               end else if (hold_reg == 10'd0) begin
                  state_next = SRC_A;
               end else begin
                  hold_next = hold_reg - 10'd1;
               end
            end
            SRC_B_FORCE: begin
               // Requests collected while forced stay pending and re-arm the hold on release.
               if (!M) begin
                  if (req) begin
                     state_next   = SRC_B_HOLD;
                     hold_next    = HOLD_RELOAD;
                     pending_next = 1'b0;
                  end else begin
                     state_next = SRC_A;
                  end
               end
            end
            default: state_next = SRC_A;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= SRC_A;
         hold_reg      <= 10'd0;
         pending_reg   <= 1'b0;
         showing_b_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         hold_reg      <= hold_next;
         pending_reg   <= pending_next;
         showing_b_reg <= (state_next != SRC_A);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_reg   <= 2'd3;
         blank_reg <= 4'd0;
         wait_reg  <= 1'b0;
         an_reg    <= 4'hF;
         c_reg     <= 7'h7F;
      end else if (scan_tick) begin
         idx_reg   <= idx_reg - 2'd1;
         blank_reg <= BLANK_LOAD;
         wait_reg  <= 1'b1;
         an_reg    <= 4'hF;
         c_reg     <= 7'h7F;
      end else if (wait_reg) begin
         if (blank_reg == 4'd0) begin
            wait_reg <= 1'b0;
            an_reg   <= ~(4'b0001 << idx_reg);
            c_reg    <= cur_code;
         end else begin
            blank_reg <= blank_reg - 4'd1;
         end
      end else if (an_reg != 4'hF) begin
         // Segment codes follow the live source while the digit is lit.
         c_reg <= cur_code;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_reg <= 8'd0;
         led_reg   <= 1'b0;
      end else if (!overflow) begin
         blink_reg <= 8'd0;
         led_reg   <= 1'b0;
      end else if (frame_tick) begin
         if (blink_reg == 8'd0) begin
            led_reg   <= ~led_reg;
            blink_reg <= BLINK_RELOAD;
         end else begin
            blink_reg <= blink_reg - 8'd1;
         end
      end
   end

   assign C            = c_reg;
   assign AN3          = an_reg[3];
   assign AN2          = an_reg[2];
   assign AN1          = an_reg[1];
   assign AN0          = an_reg[0];
   assign showing_b    = showing_b_reg;
   assign overflow_led = led_reg;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler: scan timing, hold/re-arm/force arbitration,
// overflow blink and asynchronous reset, with hand-derived expectations.
module tb_display_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        scan_tick;
   logic [27:0] src_a;
   logic [27:0] src_b;
   logic        b_req;
   logic        M;
   logic        overflow;
   logic [6:0]  C;
   logic        AN3, AN2, AN1, AN0;
   logic        showing_b;
   logic        overflow_led;

   int          errors = 0;
   int          checks = 0;
   logic [1:0]  b_idx;

   display_scheduler #(
      .HOLD_FRAMES (3),
      .BLANK_CYCLES(4),
      .BLINK_FRAMES(2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .scan_tick   (scan_tick),
      .src_a       (src_a),
      .src_b       (src_b),
      .b_req       (b_req),
      .M           (M),
      .overflow    (overflow),
      .C           (C),
      .AN3         (AN3),
      .AN2         (AN2),
      .AN1         (AN1),
      .AN0         (AN0),
      .showing_b   (showing_b),
      .overflow_led(overflow_led)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] digit_code(input logic [27:0] s, input logic [1:0] d);
      return s[d*7 +: 7];
   endfunction

   function automatic logic [3:0] an_for(input logic [1:0] d);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << d);
   endfunction

   task automatic tick(input int gap);
      scan_tick = 1'b1;
      @(negedge clk);
      scan_tick = 1'b0;
      b_idx = b_idx - 2'd1;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic pulse_b_req();
      b_req = 1'b1;
      @(negedge clk);
      b_req = 1'b0;
   endtask

   // One frame of four ticks starting at the boundary tick; checks source, anode and code.
   task automatic run_frame(input logic exp_b, input logic req_mid, input logic m_mid,
                            input string tag);
      logic [6:0] exp_c;
      for (int t = 0; t < 4; t++) begin
         tick(10);
         checks++;
         if (showing_b !== exp_b) begin
            errors++;
            $display("FAIL %s showing_b digit%0d: got %b want %b", tag, b_idx, showing_b, exp_b);
         end
         exp_c = digit_code(exp_b ? src_b : src_a, b_idx);
         checks++;
         if (C !== exp_c) begin
            errors++;
            $display("FAIL %s C digit%0d: got %h want %h", tag, b_idx, C, exp_c);
         end
         checks++;
         if ({AN3, AN2, AN1, AN0} !== an_for(b_idx)) begin
            errors++;
            $display("FAIL %s AN digit%0d: got %b want %b", tag, b_idx,
                     {AN3, AN2, AN1, AN0}, an_for(b_idx));
         end
         if (t == 1) begin
            M = m_mid;
            if (req_mid) pulse_b_req();
         end
      end
      $display("frame %s: showing_b expected %b", tag, exp_b);
   endtask

   task automatic test_reset();
      checks++;
      if ({AN3, AN2, AN1, AN0} !== 4'hF || C !== 7'h7F) begin
         errors++;
         $display("FAIL reset_blank: got AN=%b C=%h want AN=1111 C=7f", {AN3, AN2, AN1, AN0}, C);
      end
      checks++;
      if (showing_b !== 1'b0 || overflow_led !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got showing_b=%b led=%b want 0 0", showing_b, overflow_led);
      end
      $display("reset: outputs checked while rst low");
      @(negedge clk);
      rst = 1'b1;
      b_idx = 2'd3;
   endtask

   task automatic test_scan();
      int cnt [4];
      int others;
      int overlap;
      logic [3:0] an_now;
      overlap = 0;
      for (int k = 0; k < 6; k++) begin
         foreach (cnt[j]) cnt[j] = 0;
         scan_tick = 1'b1;
         @(negedge clk);
         scan_tick = 1'b0;
         b_idx = b_idx - 2'd1;
         for (int i = 0; i < 100; i++) begin
            an_now = {AN3, AN2, AN1, AN0};
            for (int j = 0; j < 4; j++) if (!an_now[j]) cnt[j]++;
            if ($countones(~an_now) > 1) overlap++;
            if (i < 99) @(negedge clk);
         end
         checks++;
         if (cnt[b_idx] != 95) begin
            errors++;
            $display("FAIL scan_low_time AN%0d: got %0d cycles want 95", b_idx, cnt[b_idx]);
         end
         others = cnt[0] + cnt[1] + cnt[2] + cnt[3] - cnt[b_idx];
         checks++;
         if (others != 0) begin
            errors++;
            $display("FAIL scan_order tick%0d: got %0d low cycles on other anodes want 0", k, others);
         end
         checks++;
         if (C !== digit_code(src_a, b_idx)) begin
            errors++;
            $display("FAIL scan_code AN%0d: got %h want %h", b_idx, C, digit_code(src_a, b_idx));
         end
         $display("scan tick %0d: AN%0d low %0d cycles", k, b_idx, cnt[b_idx]);
      end
      checks++;
      if (overlap != 0) begin
         errors++;
         $display("FAIL scan_overlap: got %0d cycles with two anodes low want 0", overlap);
      end
   endtask

   task automatic test_skip();
      tick(10);
      tick(10);
      tick(2);
      checks++;
      if ({AN3, AN2, AN1, AN0} !== 4'hF) begin
         errors++;
         $display("FAIL skip_blank: got AN=%b want 1111", {AN3, AN2, AN1, AN0});
      end
      tick(10);
      checks++;
      if ({AN3, AN2, AN1, AN0} !== 4'b1101) begin
         errors++;
         $display("FAIL skip_digit: got AN=%b want 1101", {AN3, AN2, AN1, AN0});
      end
      $display("skip: tick during blanking lands on AN1");
      tick(10);
   endtask

   task automatic test_hold();
      run_frame(1'b0, 1'b1, 1'b0, "hold_req");
      run_frame(1'b1, 1'b0, 1'b0, "hold_b1");
      run_frame(1'b1, 1'b0, 1'b0, "hold_b2");
      run_frame(1'b1, 1'b0, 1'b0, "hold_b3");
      run_frame(1'b0, 1'b0, 1'b0, "hold_back_a");
   endtask

   task automatic test_rearm();
      run_frame(1'b0, 1'b1, 1'b0, "rearm_req");
      run_frame(1'b1, 1'b0, 1'b0, "rearm_b1");
      run_frame(1'b1, 1'b1, 1'b0, "rearm_b2");
      run_frame(1'b1, 1'b0, 1'b0, "rearm_b3");
      run_frame(1'b1, 1'b0, 1'b0, "rearm_b4");
      run_frame(1'b1, 1'b0, 1'b0, "rearm_b5");
      run_frame(1'b0, 1'b0, 1'b0, "rearm_back_a");
   endtask

   task automatic test_force();
      run_frame(1'b0, 1'b1, 1'b1, "force_req");
      run_frame(1'b1, 1'b0, 1'b1, "force_f1");
      run_frame(1'b1, 1'b1, 1'b1, "force_f2");
      run_frame(1'b1, 1'b0, 1'b1, "force_f3");
      run_frame(1'b1, 1'b0, 1'b0, "force_f4");
      run_frame(1'b1, 1'b0, 1'b0, "force_h1");
      run_frame(1'b1, 1'b0, 1'b0, "force_h2");
      run_frame(1'b1, 1'b0, 1'b0, "force_h3");
      run_frame(1'b0, 1'b0, 1'b0, "force_back_a");
   endtask

   task automatic test_blink();
      logic pat [5];
      pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      overflow = 1'b1;
      for (int f = 0; f < 5; f++) begin
         tick(10);
         checks++;
         if (overflow_led !== pat[f]) begin
            errors++;
            $display("FAIL blink_boundary%0d: got %b want %b", f, overflow_led, pat[f]);
         end
         tick(10);
         tick(10);
         tick(10);
         checks++;
         if (overflow_led !== pat[f]) begin
            errors++;
            $display("FAIL blink_midframe%0d: got %b want %b", f, overflow_led, pat[f]);
         end
         $display("blink frame %0d: led %b", f, overflow_led);
      end
      overflow = 1'b0;
      @(negedge clk);
      checks++;
      if (overflow_led !== 1'b0) begin
         errors++;
         $display("FAIL blink_clear: got %b want 0", overflow_led);
      end
      overflow = 1'b1;
      tick(10);
      checks++;
      if (overflow_led !== 1'b1) begin
         errors++;
         $display("FAIL blink_restart: got %b want 1", overflow_led);
      end
      $display("blink: cleared then restarted");
      tick(10);
      tick(10);
      tick(10);
   endtask

   task automatic test_reset_mid();
      run_frame(1'b0, 1'b1, 1'b0, "rst_req");
      tick(10);
      checks++;
      if (showing_b !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_b: got %b want 1", showing_b);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({AN3, AN2, AN1, AN0} !== 4'hF || C !== 7'h7F || showing_b !== 1'b0) begin
         errors++;
         $display("FAIL rst_async: got AN=%b C=%h showing_b=%b want 1111 7f 0",
                  {AN3, AN2, AN1, AN0}, C, showing_b);
      end
      checks++;
      if (overflow_led !== 1'b0) begin
         errors++;
         $display("FAIL rst_led: got %b want 0", overflow_led);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      b_idx = 2'd3;
      tick(10);
      checks++;
      if ({AN3, AN2, AN1, AN0} !== 4'b1011 || C !== digit_code(src_a, 2'd2)) begin
         errors++;
         $display("FAIL rst_first_digit: got AN=%b C=%h want 1011 %h",
                  {AN3, AN2, AN1, AN0}, C, digit_code(src_a, 2'd2));
      end
      $display("reset mid-frame: first lit digit AN%0d", b_idx);
   endtask

   initial begin
      rst       = 1'b0;
      scan_tick = 1'b0;
      b_req     = 1'b0;
      M         = 1'b0;
      overflow  = 1'b0;
      src_a     = {7'h11, 7'h22, 7'h33, 7'h44};
      src_b     = {7'h5A, 7'h6B, 7'h0C, 7'h1D};
      b_idx     = 2'd3;
      repeat (3) @(negedge clk);
      test_reset();
      test_scan();
      test_skip();
      test_hold();
      test_rearm();
      test_force();
      test_blink();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
